// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide engine feeding the Hi/Lo registers (MULT, MULTU, DIV, DIVU).
// Define MULDIV_FAST_MULT_EN to give MULT/MULTU a single-cycle combinational path; division stays iterative.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_we,
    output logic             lo_we
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   opnd_q, rs_q, hi_q, lo_q;
    logic [CW-1:0]      cnt;
    logic               neg_q, rem_neg_q, is_div_q, div_zero_q;

    logic               accept, last_iter, op_signed, div_ge;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt == CW'(ITER - 1));
    assign op_signed = ~op[0];
    assign rs_mag    = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag    = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc low half shifts dividend out, quotient in.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = (rem << 1) | {{WIDTH{1'b0}}, acc[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});

    always_ff @(posedge clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_next = op[1] ? DIV : FIX;
`else
                    state_next = op[1] ? DIV : MUL;
`endif
                end
            end
            MUL:     if (last_iter) state_next = FIX;
            DIV:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            acc        <= '0;
            rem        <= '0;
            opnd_q     <= '0;
            rs_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div_q   <= op[1];
                        neg_q      <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        rem_neg_q  <= op_signed && rs_val[WIDTH-1];
                        div_zero_q <= op[1] && (rt_val == '0);
                        rs_q       <= rs_val;
                        opnd_q     <= op[1] ? rt_mag : rs_mag;
                        rem        <= '0;
                        cnt        <= '0;
`ifdef MULDIV_FAST_MULT_EN
                        if (!op[1])
                            acc <= {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
                        else
                            acc <= {{WIDTH{1'b0}}, rs_mag};
`else
                        acc <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
`endif
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    rem            <= div_ge ? (div_shift - {1'b0, opnd_q}) : div_shift;
                    acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
                    cnt            <= cnt + 1'b1;
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    // Sign correction happens here on the magnitude result; divide-by-zero bypasses it entirely.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                fix_hi = rs_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem_neg_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
        busy   = (state != IDLE);
        done   = (state == FIX);
        hi_we  = done;
        lo_we  = done;
        hi_out = done ? fix_hi : hi_q;
        lo_out = done ? fix_lo : lo_q;
    end

endmodule
